// File: rtl/mbus_ctrl_pkg.sv
// Shared types and defaults for the MBus root controller.
// Holds the controller state encoding and a ceiling-log2 helper for counter sizing.
package mbus_ctrl_pkg;

    localparam int unsigned DefDivW            = 8;
    localparam int unsigned DefDivDefault      = 10;
    localparam int unsigned DefStartHalfCycles = 6;
    localparam int unsigned DefResetCycles     = 7;
    localparam int unsigned DefIntToggles      = 4;
    localparam int unsigned DefMaxBusCycles    = 0;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StRunLo,
        StRunHi,
        StFint,
        StRstHi,
        StRstLo
    } state_e;

    // Bits needed to hold values 0..v-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mbus_half_period_timer.sv
// Free-running half-period timer: counts len-1 down to 0 and pulses tc at 0.
// The length is captured on load and reused for every reload until the next load.
module mbus_half_period_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] len,
    output logic         tc
);

    logic [W-1:0] len_q;
    logic [W-1:0] cnt_q;
    logic         run_q;
    logic [W-1:0] len_eff;

    assign len_eff = load ? len : len_q;
    assign tc      = run_q && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= W'(1);
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            if (load) begin
                len_q <= len;
            end
            if (stop) begin
                run_q <= 1'b0;
                cnt_q <= '0;
            end else if (start) begin
                run_q <= 1'b1;
                cnt_q <= len_eff - W'(1);
            end else if (run_q) begin
                cnt_q <= (cnt_q == '0) ? (len_q - W'(1)) : (cnt_q - W'(1));
            end
        end
    end

endmodule

// File: rtl/mbus_ctrl_v3.sv
// MBus ring root controller: sources the bus clock, forwards ring data, runs arbitration,
// detects node interjections and can force its own interjection or time out a transaction.
module mbus_ctrl_v3
    import mbus_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W             = DefDivW,
    parameter int unsigned DIV_DEFAULT       = DefDivDefault,
    parameter int unsigned START_HALF_CYCLES = DefStartHalfCycles,
    parameter int unsigned RESET_CYCLES      = DefResetCycles,
    parameter int unsigned INT_TOGGLES       = DefIntToggles,
    parameter int unsigned MAX_BUS_CYCLES    = DefMaxBusCycles
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             din,
    output logic             dout,
    output logic             clk_out,
    input  logic             div_sel,
    input  logic [DIV_W-1:0] div,
    input  logic             force_int,
    output logic             busy,
    output logic             int_done,
    output logic             timeout
);

    localparam int unsigned HalfMax =
        ((START_HALF_CYCLES > INT_TOGGLES) ? START_HALF_CYCLES : INT_TOGGLES) - 1;
    localparam int unsigned HalfW = clog2(HalfMax + 1);
    localparam int unsigned RstW  = clog2(RESET_CYCLES);
    localparam int unsigned BusW  = clog2(MAX_BUS_CYCLES + 1);

    localparam logic [HalfW-1:0] ArbLoad  = HalfW'(START_HALF_CYCLES - 1);
    localparam logic [HalfW-1:0] FintLoad = HalfW'(INT_TOGGLES - 1);
    localparam logic [RstW-1:0]  RstLoad  = RstW'(RESET_CYCLES - 1);
    localparam logic [BusW-1:0]  BusMax   = BusW'(MAX_BUS_CYCLES);

    state_e            state_q, state_d;
    logic [HalfW-1:0]  half_q, half_d;
    logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [1:0]        hist_q, hist_d;
    logic              tog_q, tog_d;
    logic [BusW-1:0]   bus_q, bus_d;
    logic [BusW-1:0]   bus_inc;
    logic              int_done_q, int_done_d;
    logic              timeout_q, timeout_d;
    logic              wd_expired;
    logic [DIV_W-1:0]  h_sel;
    logic              tc;
    logic              t_load, t_start, t_stop;

    assign h_sel      = div_sel ? ((div == '0) ? DIV_W'(1) : div) : DIV_W'(DIV_DEFAULT);
    assign bus_inc    = bus_q + BusW'(1);
    assign wd_expired = (MAX_BUS_CYCLES != 0) && (bus_q == BusMax);

    mbus_half_period_timer #(
        .W(DIV_W)
    ) u_timer (
        .clk  (clk_in),
        .rst_n(rst_n),
        .load (t_load),
        .start(t_start),
        .stop (t_stop),
        .len  (h_sel),
        .tc   (tc)
    );

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        rst_cnt_d  = rst_cnt_q;
        hist_d     = hist_q;
        tog_d      = tog_q;
        bus_d      = bus_q;
        int_done_d = 1'b0;
        timeout_d  = 1'b0;
        t_load     = 1'b0;
        t_start    = 1'b0;
        t_stop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!din) begin
                    state_d = StArb;
                    half_d  = ArbLoad;
                    t_load  = 1'b1;
                    t_start = 1'b1;
                end
            end
            StArb: begin
                if (tc) begin
                    if (half_q == '0) state_d = StRunLo;
                    else              half_d  = half_q - HalfW'(1);
                end
            end
            StRunLo: begin
                if (tc) begin
                    state_d = StRunHi;
                    hist_d  = {hist_q[0], din};
                end
            end
            StRunHi: begin
                // Detect beats a forced or watchdog interjection; restart so RST_HI is a full half.
                if (hist_q[1] ^ hist_q[0]) begin
                    state_d   = StRstHi;
                    rst_cnt_d = RstLoad;
                    t_start   = 1'b1;
                end else if (tc) begin
                    if (force_int || wd_expired) begin
                        state_d = StFint;
                        tog_d   = din;
                        half_d  = FintLoad;
                    end else begin
                        state_d = StRunLo;
                        if (bus_q != BusMax) begin
                            bus_d     = bus_inc;
                            timeout_d = (bus_inc == BusMax);
                        end
                    end
                end
            end
            StFint: begin
                if (tc) begin
                    if (half_q == '0) begin
                        state_d   = StRstHi;
                        rst_cnt_d = RstLoad;
                    end else begin
                        half_d = half_q - HalfW'(1);
                        tog_d  = ~tog_q;
                    end
                end
            end
            StRstHi: begin
                if (tc) state_d = StRstLo;
            end
            StRstLo: begin
                if (tc) begin
                    if (rst_cnt_q != '0) begin
                        rst_cnt_d = rst_cnt_q - RstW'(1);
                        state_d   = StRstHi;
                    end else begin
                        state_d    = StIdle;
                        t_stop     = 1'b1;
                        hist_d     = 2'b00;
                        bus_d      = '0;
                        int_done_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            half_q     <= '0;
            rst_cnt_q  <= '0;
            hist_q     <= 2'b00;
            tog_q      <= 1'b1;
            bus_q      <= '0;
            int_done_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            rst_cnt_q  <= rst_cnt_d;
            hist_q     <= hist_d;
            tog_q      <= tog_d;
            bus_q      <= bus_d;
            int_done_q <= int_done_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        busy     = (state_q != StIdle);
        clk_out  = !((state_q == StRunLo) || (state_q == StRstLo));
        int_done = int_done_q;
        timeout  = timeout_q;
        if (state_q == StIdle)      dout = 1'b1;
        else if (state_q == StFint) dout = tog_q;
        else                        dout = din;
    end

endmodule

// File: tb/tb_mbus_ctrl_v3.sv
// Bench for mbus_ctrl_v3: two instances (watchdog off / limit 5) share stimulus and are
// checked every cycle against an elapsed-time model, plus directed literal timing checks.
module tb_mbus_ctrl_v3;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b1;
    logic       div_sel = 1'b0;
    logic [7:0] div = 8'd0;
    logic       force_int = 1'b0;

    logic clk_out0, dout0, busy0, int_done0, timeout0;
    logic clk_out1, dout1, busy1, int_done1, timeout1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    mbus_ctrl_v3 u_dut (
        .clk_in(clk_in), .rst_n(rst_n), .din(din), .dout(dout0), .clk_out(clk_out0),
        .div_sel(div_sel), .div(div), .force_int(force_int), .busy(busy0),
        .int_done(int_done0), .timeout(timeout0)
    );

    mbus_ctrl_v3 #(
        .MAX_BUS_CYCLES(5)
    ) u_wd (
        .clk_in(clk_in), .rst_n(rst_n), .din(din), .dout(dout1), .clk_out(clk_out1),
        .div_sel(div_sel), .div(div), .force_int(force_int), .busy(busy1),
        .int_done(int_done1), .timeout(timeout1)
    );

    // Model: phase plus cycles elapsed in it; bus clock and toggles derived arithmetically.
    localparam int P_IDLE = 0, P_ARB = 1, P_RUN = 2, P_FINT = 3, P_RST = 4;
    int ph[2], el[2], hh[2], h1[2], h0[2], nb[2], fd0[2], tx[2], ix[2];

    task automatic m_reset(input int m);
        ph[m] = P_IDLE; el[m] = 0; hh[m] = 10; h1[m] = 0; h0[m] = 0;
        nb[m] = 0; fd0[m] = 0; tx[m] = 0; ix[m] = 0;
    endtask

    task automatic m_step(input int m);
        int pos, mx, ntx, nix;
        mx = (m == 0) ? 0 : 5;
        ntx = 0;
        nix = 0;
        case (ph[m])
            P_IDLE: if (din == 1'b0) begin
                ph[m] = P_ARB; el[m] = 0;
                hh[m] = div_sel ? ((div == 8'd0) ? 1 : int'(div)) : 10;
            end
            P_ARB: if (el[m] == 6 * hh[m] - 1) begin ph[m] = P_RUN; el[m] = 0; end
                   else el[m]++;
            P_RUN: begin
                pos = el[m] % (2 * hh[m]);
                if (pos < hh[m]) begin
                    if (pos == hh[m] - 1) begin h1[m] = h0[m]; h0[m] = int'(din); end
                    el[m]++;
                end else if (h1[m] != h0[m]) begin
                    ph[m] = P_RST; el[m] = 0;
                end else if (pos == 2 * hh[m] - 1) begin
                    if (force_int || (mx != 0 && nb[m] == mx)) begin
                        ph[m] = P_FINT; el[m] = 0; fd0[m] = int'(din);
                    end else begin
                        el[m] = 0;
                        if (nb[m] < mx) begin
                            nb[m]++;
                            if (nb[m] == mx) ntx = 1;
                        end
                    end
                end else el[m]++;
            end
            P_FINT: if (el[m] == 4 * hh[m] - 1) begin ph[m] = P_RST; el[m] = 0; end
                    else el[m]++;
            P_RST: if (el[m] == 7 * 2 * hh[m] - 1) begin
                ph[m] = P_IDLE; el[m] = 0; h1[m] = 0; h0[m] = 0; nb[m] = 0; nix = 1;
            end else el[m]++;
            default: ph[m] = P_IDLE;
        endcase
        tx[m] = ntx;
        ix[m] = nix;
    endtask

    function automatic logic [4:0] m_out(input int m);
        logic c, d;
        c = 1'b1;
        d = din;
        case (ph[m])
            P_IDLE: d = 1'b1;
            P_RUN:  c = (el[m] % (2 * hh[m])) >= hh[m];
            P_FINT: d = ((fd0[m] ^ ((el[m] / hh[m]) & 1)) != 0);
            P_RST:  c = ((el[m] / hh[m]) % 2) == 0;
            default: ;
        endcase
        return {c, d, ph[m] != P_IDLE, ix[m] != 0, tx[m] != 0};
    endfunction

    always @(posedge clk_in or negedge rst_n) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) m_reset(m);
            else        m_step(m);
        end
    end

    always @(negedge clk_in) begin
        checks++;
        if ({clk_out0, dout0, busy0, int_done0, timeout0} !== m_out(0)) begin
            errors++;
            $display("FAIL model dut0 @%0d: got %b expected %b (clk,dout,busy,done,to)", cyc,
                     {clk_out0, dout0, busy0, int_done0, timeout0}, m_out(0));
        end
        checks++;
        if ({clk_out1, dout1, busy1, int_done1, timeout1} !== m_out(1)) begin
            errors++;
            $display("FAIL model dut_wd @%0d: got %b expected %b (clk,dout,busy,done,to)", cyc,
                     {clk_out1, dout1, busy1, int_done1, timeout1}, m_out(1));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit sig(input int w);
        case (w)
            0: return busy0;
            1: return !clk_out0;
            2: return clk_out0;
            3: return timeout1;
            4: return int_done1;
            5: return int_done0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int w, input string name, input int bound);
        int n;
        n = 0;
        @(negedge clk_in);
        while (!sig(w) && n < bound) begin
            @(negedge clk_in);
            n++;
        end
        if (!sig(w)) begin
            checks++;
            errors++;
            $display("FAIL wait %s: got nothing expected event within %0d cycles", name, bound);
        end
    endtask

    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (clk_out0 === lvl && n < 500) begin
            n++;
            @(negedge clk_in);
        end
    endtask

    task automatic drive;
        @(posedge clk_in);
        #2;
    endtask

    task automatic reset_pulse(input string tag);
        drive();
        rst_n = 1'b0;
        force_int = 1'b0;
        din = 1'b1;
        #1;
        chk({tag, "_dut0"}, int'({clk_out0, dout0, busy0, int_done0, timeout0}), 5'b11000);
        chk({tag, "_wd"}, int'({clk_out1, dout1, busy1, int_done1, timeout1}), 5'b11000);
        drive();
        rst_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n, t0;
        #3;
        chk("reset_outputs", int'({clk_out0, dout0, busy0, int_done0, timeout0}), 5'b11000);

        // Basic arbitration, clocking and watchdog.
        reset_pulse("rst_basic");
        drive(); din = 1'b0;
        wait_sig(0, "busy", 10);
        t0 = cyc;
        measure(1'b1, n); chk("arb_high", n, 60);
        measure(1'b0, n); chk("run_low", n, 10);
        measure(1'b1, n); chk("run_high", n, 10);
        wait_sig(3, "timeout", 300);
        chk("timeout_time", cyc - t0, 160);
        wait_sig(4, "wd_int_done", 400);
        chk("wd_int_done_time", cyc - t0, 360);

        // Forced interjection, then async reset mid-RST_LO.
        reset_pulse("rst_pre_force");
        drive(); din = 1'b0;
        wait_sig(1, "force_lo", 100);
        drive(); force_int = 1'b1;
        wait_sig(2, "force_hi", 30);
        measure(1'b1, n); chk("force_high_run", n, 60);
        reset_pulse("rst_mid_rstlo");

        // Async reset mid-FINT, then a fresh transaction.
        drive(); din = 1'b0;
        wait_sig(1, "fint_lo", 100);
        drive(); force_int = 1'b1;
        wait_sig(2, "fint_hi", 30);
        repeat (30) @(negedge clk_in);
        reset_pulse("rst_mid_fint");
        drive(); din = 1'b0;
        wait_sig(0, "busy_fresh", 10);
        measure(1'b1, n); chk("fresh_arb_high", n, 60);
        measure(1'b0, n); chk("fresh_run_low", n, 10);

        // Node interjection with a simultaneous FORCE_INT.
        reset_pulse("rst_node");
        drive(); din = 1'b0;
        wait_sig(1, "node_lo1", 100);
        wait_sig(2, "node_hi1", 30);
        wait_sig(1, "node_lo2", 30);
        drive(); din = 1'b1; force_int = 1'b1;
        wait_sig(2, "node_hi2", 30);
        measure(1'b1, n); chk("detect_high_run", n, 11);
        drive(); force_int = 1'b0;
        wait_sig(5, "node_int_done", 200);
        chk("idle_busy", int'(busy0), 0);
        chk("idle_dout", int'(dout0), 1);
        n = 0;
        repeat (30) begin
            @(negedge clk_in);
            if (int_done0) n++;
        end
        chk("int_done_once", n, 0);

        // Runtime divider.
        reset_pulse("rst_div");
        drive(); div_sel = 1'b1; div = 8'd3; din = 1'b0;
        wait_sig(1, "div3_lo", 50);
        drive(); div = 8'd7;
        wait_sig(2, "div3_hi", 10);
        measure(1'b1, n); chk("div3_high", n, 3);
        measure(1'b0, n); chk("div3_low", n, 3);
        drive(); din = 1'b1;
        wait_sig(5, "div3_done", 100);
        drive(); din = 1'b0;
        wait_sig(0, "div7_busy", 10);
        measure(1'b1, n); chk("div7_arb_high", n, 42);
        measure(1'b0, n); chk("div7_low", n, 7);
        drive(); din = 1'b1;
        wait_sig(5, "div7_done", 200);
        drive(); div = 8'd0; din = 1'b0;
        wait_sig(0, "div0_busy", 10);
        measure(1'b1, n); chk("div0_arb_high", n, 6);
        measure(1'b0, n); chk("div0_low", n, 1);
        measure(1'b1, n); chk("div0_high", n, 1);
        drive(); din = 1'b1;
        wait_sig(5, "div0_done", 50);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            drive();
            if ($urandom_range(0, 15) == 0) din = ~din;
            force_int = ($urandom_range(0, 47) == 0);
            if ($urandom_range(0, 199) == 0) begin
                div_sel = 1'($urandom_range(0, 1));
                div = 8'($urandom_range(0, 4));
            end
            rst_n = ($urandom_range(0, 999) != 0);
        end
        drive(); rst_n = 1'b1;
        repeat (5) @(negedge clk_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbus_ctrl_v3.md
# mbus_ctrl_v3

Parametrised successor to the MBus master bus controller. It sits at the root of the MBus ring, sources the bus clock (CLK_OUT), and forwards ring data from the last node (DIN) to the first node (DOUT). It runs arbitration timing and detects node-initiated interjections. It also adds three things the previous generation lacked: a runtime-selectable clock divider, controller-initiated interjection (FORCE_INT), and a transaction watchdog.

## Interface
- DIV_W, 8: width of runtime divider input.
- DIV_DEFAULT, 10: half-period length in CLK_IN cycles, used while DIV_SEL=0.
- START_HALF_CYCLES, 6: half-periods CLK_OUT stays high after DIN falls in IDLE.
- RESET_CYCLES, 7: bus-clock cycles in the reset (control) sequence.
- INT_TOGGLES, 4: DOUT toggles driven during a forced interjection (even, ≥2).
- MAX_BUS_CYCLES, 0: watchdog limit in bus cycles; 0 disables it.
- CLK_IN input 1: system clock.
- RESET input 1: one clock; reset is asynchronous and active-low.
- DIN input 1: ring data returning from the last node.
- DOUT output 1: ring data to the first node.
- CLK_OUT output 1: bus clock.
- DIV_SEL input 1: 1 selects DIV as the half-period; 0 selects DIV_DEFAULT.
- DIV input DIV_W: runtime half-period; the value 0 is treated as 1.
- FORCE_INT input 1: level request for a controller-initiated interjection.
- BUSY output 1: high in every state except IDLE.
- INT_DONE output 1: one-cycle pulse when a reset sequence completes.
- TIMEOUT output 1: one-cycle pulse when the watchdog fires.

## Operation
- Half-period length H is latched on the IDLE→ARB transition and is constant for the whole transaction. Changing DIV or DIV_SEL mid-transaction has no effect.
- The half-period timer counts H-1 down to 0. Each state transition except IDLE→ARB happens on the cycle where the count is 0.
- States, with CLK_OUT and DOUT in each:
  - IDLE: CLK_OUT=1, DOUT=1.
  - ARB: CLK_OUT=1, DOUT=DIN.
  - RUN_LO: CLK_OUT=0, DOUT=DIN.
  - RUN_HI: CLK_OUT=1, DOUT=DIN.
  - FINT: CLK_OUT=1, DOUT=toggle register.
  - RST_HI: CLK_OUT=1, DOUT=DIN.
  - RST_LO: CLK_OUT=0, DOUT=DIN.
- DOUT is combinational from DIN in every state except IDLE and FINT.
- IDLE→ARB: when DIN=0. The timer starts and the half-period counter loads START_HALF_CYCLES-1.
- ARB→RUN_LO: after START_HALF_CYCLES half-periods.
- RUN_LO→RUN_HI: at the end of the half-period. DIN is sampled on this transition, i.e. at the bus rising edge, and shifted into a 2-bit history.
- RUN_HI→RUN_LO: at the end of the half-period, unless one of the two exits below applies. The bus-cycle counter increments on this transition.
- Interjection detect, RUN_HI→RST_HI: taken when the two history bits differ; checked in every RUN_HI cycle. The reset counter loads RESET_CYCLES-1.
- Forced interjection, RUN_HI→FINT: taken at the end of the half-period when FORCE_INT=1 or the watchdog has expired.
- FINT: DOUT starts at the current DIN and inverts at each half-period end. After INT_TOGGLES half-periods the block enters RST_HI.
- RST_HI→RST_LO: at the end of the half-period.
- RST_LO: at the end of the half-period, if the reset counter is nonzero, decrement it and go to RST_HI. Otherwise go to IDLE, stop the timer, clear the history and the bus-cycle counter, and pulse INT_DONE.
- Watchdog: when MAX_BUS_CYCLES≠0 and the bus-cycle counter reaches MAX_BUS_CYCLES, TIMEOUT pulses once and FINT is taken at the next RUN_HI end.
- Simultaneous events:
  - Interjection detect and FORCE_INT or watchdog together: detect wins, and the block goes straight to RST_HI with no FINT.
  - FORCE_INT in IDLE, ARB, FINT or RST_*: ignored.
- Reset asserted at any point: the block returns to IDLE immediately and all outputs take their reset values.
- Width rules:
  - Counters are sized with the ceiling log2 of their maximum value.
  - The bus-cycle counter saturates at MAX_BUS_CYCLES.

## Timing
- Reset values:
  - CLK_OUT=1, DOUT=1, BUSY=0, INT_DONE=0, TIMEOUT=0.
  - State IDLE, timer stopped, history 00.
- DIN low at clock edge k: BUSY=1 from k+1. The first CLK_OUT fall comes START_HALF_CYCLES·H cycles after k+1.
- Bus clock period is 2H CLK_IN cycles with a 50% duty cycle.
- Interjection detect to first RST_HI cycle: 1 CLK_IN cycle.
- A full reset sequence is RESET_CYCLES·2H cycles. INT_DONE is asserted in the cycle that BUSY falls.

## Structure
- Package mbus_ctrl_pkg holds:
  - the state enum;
  - default parameter constants;
  - a clog2 function.
- One sub-module, mbus_half_period_timer, built from:
  - ports load, start, stop and the length H;
  - output tc, which pulses when the count reaches 0.
- The FSM, history, toggle register, reset counter and watchdog stay in the top level.

## Test plan
- Basic arbitration and clocking: DIV_SEL=0, DIN falls, DIN held at 0. CLK_OUT stays high for 60 cycles after BUSY rises, then toggles every 10 cycles.
- Runtime divider: DIV_SEL=1, DIV=3, start a transaction, then change DIV to 7 mid-run. Half-period stays 3; the next transaction uses 7. DIV=0 gives a half-period of 1.
- Node interjection: DIN sampled 0 then 1 at consecutive rising edges. The next cycle is RST_HI, followed by 7 CLK_OUT periods. INT_DONE pulses once, then the block is IDLE with DOUT=1.
- Forced interjection: FORCE_INT=1 during RUN_LO. At the RUN_HI end, CLK_OUT holds high for 4 half-periods while DOUT toggles 4 times, then the reset sequence runs. Also assert FORCE_INT in the same cycle as a detected interjection: no FINT occurs.
- Watchdog: MAX_BUS_CYCLES=5, DIN constant. TIMEOUT pulses after 5 bus cycles, then FINT, reset sequence and INT_DONE follow.
- Async reset mid-FINT and mid-RST_LO: all outputs reach their reset values with no CLK_IN edge. A fresh transaction then behaves as in the first scenario.
